// File: rtl/interrupt_controller_if.sv
// Handshake bundle between the interrupt controller and the hazard control unit.
//   int_ack                  : hazard unit has entered its interrupt state (pulse)
//   int_return               : handler return has been issued (pulse)
//   interrupt                : request to the hazard unit
//   interrupt_vector_address : handler address of the current request
//   in_service               : a handler is executing
//   active_irq               : index of the requested or in-service line
// The master modport is the controller side; slave is the hazard unit side.
interface interrupt_controller_if;
   logic        int_ack;
   logic        int_return;
   logic        interrupt;
   logic [13:0] interrupt_vector_address;
   logic        in_service;
   logic [3:0]  active_irq;

   modport master (
      input  int_ack,
      input  int_return,
      output interrupt,
      output interrupt_vector_address,
      output in_service,
      output active_irq
   );

   modport slave (
      output int_ack,
      output int_return,
      input  interrupt,
      input  interrupt_vector_address,
      input  in_service,
      input  active_irq
   );
endinterface

// File: rtl/interrupt_controller.sv
// Interrupt source for the hazard control unit. Latches rising edges of the
// request lines as pending, masks them with the enable register, picks the
// lowest-index candidate and raises one request with its vector address.
// The request is held until acknowledged, then the line is tracked as in
// service until the handler returns. No nesting.
//
// Ports:
//   clock, reset       : system clock, synchronous active-high reset
//   irq_lines          : raw request lines (rising edge = request)
//   irq_enable_we/wdata: enable register write port
//   global_enable      : 0 blocks new requests from being raised
//   pending            : pending register readback
//   irq_enable         : enable register readback
//   hz                 : handshake with the hazard unit (master side)
//
// state     | meaning
// ----------+-----------------------------------------------------------
// S_IDLE    | no request outstanding, selecting among enabled pending lines
// S_REQUEST | interrupt raised, index and vector frozen, waiting for int_ack
// S_SERVICE | handler running, waiting for int_return; no new requests
module interrupt_controller #(
   parameter int          NUM_IRQ       = 8,
   parameter logic [13:0] VECTOR_BASE   = 14'h0010,
   parameter int          VECTOR_STRIDE = 4
) (
   input  logic               clock,
   input  logic               reset,
   input  logic [NUM_IRQ-1:0] irq_lines,
   input  logic               irq_enable_we,
   input  logic [NUM_IRQ-1:0] irq_enable_wdata,
   input  logic               global_enable,
   output logic [NUM_IRQ-1:0] pending,
   output logic [NUM_IRQ-1:0] irq_enable,
   interrupt_controller_if.master hz
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_REQUEST,
      S_SERVICE
   } state_t;

   state_t state;
   state_t state_next;

   logic [NUM_IRQ-1:0] irq_prev;
   logic [NUM_IRQ-1:0] edges;
   logic [NUM_IRQ-1:0] candidates;
   logic [NUM_IRQ-1:0] clr_mask;
   logic [3:0]         win_idx;
   logic [13:0]        win_vector;
   logic               load;
   logic               ack_take;

   assign edges      = irq_lines & ~irq_prev;
   assign candidates = pending & irq_enable;

   // Lowest index wins: scan from the top so the last hit is the lowest.
   always_comb begin
      win_idx = '0;
      for (int i = NUM_IRQ - 1; i >= 0; i--) begin
         if (candidates[i]) begin
            win_idx = 4'(i);
         end
      end
   end

   // 14-bit arithmetic gives the mod 2^14 wrap directly.
   assign win_vector = VECTOR_BASE + (14'(win_idx) * 14'(VECTOR_STRIDE));

   // An edge on the active line in the ack cycle re-sets the bit, because
   // the set term is OR-ed in after the clear.
   always_comb begin
      clr_mask = '0;
      for (int i = 0; i < NUM_IRQ; i++) begin
         clr_mask[i] = ack_take && (hz.active_irq == 4'(i));
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state <= S_IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      load       = 1'b0;
      ack_take   = 1'b0;
      case (state)
         S_IDLE: begin
            if (global_enable && (candidates != '0)) begin
               state_next = S_REQUEST;
               load       = 1'b1;
            end
         end
         S_REQUEST: begin
            if (hz.int_ack) begin
               state_next = S_SERVICE;
               ack_take   = 1'b1;
            end
         end
         S_SERVICE: begin
            if (hz.int_return) begin
               state_next = S_IDLE;
            end
         end
         default: begin
            state_next = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         irq_prev                    <= '0;
         pending                     <= '0;
         irq_enable                  <= '0;
         hz.active_irq               <= '0;
         hz.interrupt_vector_address <= '0;
         hz.interrupt                <= 1'b0;
         hz.in_service               <= 1'b0;
      end else begin
         irq_prev <= irq_lines;
         pending  <= (pending & ~clr_mask) | edges;
         if (irq_enable_we) begin
            irq_enable <= irq_enable_wdata;
         end
         if (load) begin
            hz.active_irq               <= win_idx;
            hz.interrupt_vector_address <= win_vector;
         end
         hz.interrupt  <= (state_next == S_REQUEST);
         hz.in_service <= (state_next == S_SERVICE);
      end
   end

endmodule

// File: tb/tb_interrupt_controller.sv
module tb_interrupt_controller;

   logic       clock = 1'b0;
   logic       reset;
   logic [7:0] irq_lines;
   logic       irq_enable_we;
   logic [7:0] irq_enable_wdata;
   logic       global_enable;
   logic [7:0] pending;
   logic [7:0] irq_enable;

   logic [7:0] w_lines;
   logic       w_we;
   logic [7:0] w_wdata;
   logic [7:0] w_pending;
   logic [7:0] w_enable;

   interrupt_controller_if hz ();
   interrupt_controller_if w_hz ();

   interrupt_controller #(.NUM_IRQ(8)) dut (
      .clock            (clock),
      .reset            (reset),
      .irq_lines        (irq_lines),
      .irq_enable_we    (irq_enable_we),
      .irq_enable_wdata (irq_enable_wdata),
      .global_enable    (global_enable),
      .pending          (pending),
      .irq_enable       (irq_enable),
      .hz               (hz)
   );

   interrupt_controller #(.NUM_IRQ(8), .VECTOR_BASE(14'h3FFC)) dut_wrap (
      .clock            (clock),
      .reset            (reset),
      .irq_lines        (w_lines),
      .irq_enable_we    (w_we),
      .irq_enable_wdata (w_wdata),
      .global_enable    (global_enable),
      .pending          (w_pending),
      .irq_enable       (w_enable),
      .hz               (w_hz)
   );

   always #5 clock = ~clock;

   int cyc = 0;
   always @(posedge clock) cyc <= cyc + 1;

   typedef struct {
      int line;
      int vec;
      int at;
   } exp_t;

   exp_t exp_q[$];
   int   n_checks = 0;
   int   n_fail   = 0;

   task automatic check(input string name, input int act, input int req);
      n_checks++;
      if (act != req) begin
         n_fail++;
         $display("FAIL %s actual=0x%0h required=0x%0h (cycle %0d)", name, act, req, cyc);
      end
   endtask

   task automatic tick(input int n = 1);
      repeat (n) @(negedge clock);
   endtask

   task automatic expect_req(input int line, input int vec, input int at);
      exp_t e;
      e.line = line;
      e.vec  = vec;
      e.at   = at;
      exp_q.push_back(e);
   endtask

   task automatic wait_drained(input string name);
      int budget = 20;
      while (exp_q.size() != 0 && budget > 0) begin
         tick();
         budget--;
      end
      if (exp_q.size() != 0) begin
         check({name, "_timeout"}, exp_q.size(), 0);
         exp_q.delete();
      end
   endtask

   task automatic pulse_ack();
      hz.int_ack = 1'b1;
      tick();
      hz.int_ack = 1'b0;
   endtask

   task automatic pulse_ret();
      hz.int_return = 1'b1;
      tick();
      hz.int_return = 1'b0;
   endtask

   // Monitor: every new request presented by the DUT is matched against the
   // oldest expected request (line, vector and the cycle it must appear on).
   initial begin : monitor
      logic prev_int;
      exp_t e;
      prev_int = 1'b0;
      forever begin
         @(negedge clock);
         if (hz.interrupt && !prev_int) begin
            if (exp_q.size() == 0) begin
               check("unexpected_request", int'(hz.active_irq), -1);
            end else begin
               e = exp_q.pop_front();
               check("req_line",   int'(hz.active_irq), e.line);
               check("req_vector", int'(hz.interrupt_vector_address), e.vec);
               check("req_cycle",  cyc, e.at);
            end
         end
         prev_int = hz.interrupt;
      end
   end

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog actual=running required=finished");
      $fatal(1, "watchdog expired");
   end

   initial begin : stimulus
      int c;
      reset            = 1'b1;
      irq_lines        = '0;
      irq_enable_we    = 1'b0;
      irq_enable_wdata = '0;
      global_enable    = 1'b0;
      hz.int_ack       = 1'b0;
      hz.int_return    = 1'b0;
      w_lines          = '0;
      w_we             = 1'b0;
      w_wdata          = '0;
      w_hz.int_ack     = 1'b0;
      w_hz.int_return  = 1'b0;
      tick(2);
      reset = 1'b0;
      tick();

      check("rst_interrupt",  int'(hz.interrupt), 0);
      check("rst_vector",     int'(hz.interrupt_vector_address), 0);
      check("rst_in_service", int'(hz.in_service), 0);
      check("rst_active",     int'(hz.active_irq), 0);
      check("rst_pending",    int'(pending), 0);
      check("rst_enable",     int'(irq_enable), 0);

      // single request on line 3
      irq_enable_we = 1'b1; irq_enable_wdata = 8'hFF;
      tick();
      irq_enable_we = 1'b0;
      global_enable = 1'b1;
      c = cyc;
      irq_lines[3] = 1'b1;
      expect_req(3, 'h1C, c + 2);
      tick();
      check("s1_pending_set", int'(pending), 'h08);
      irq_lines[3] = 1'b0;
      wait_drained("s1");
      pulse_ack();
      check("s1_ack_interrupt",  int'(hz.interrupt), 0);
      check("s1_ack_in_service", int'(hz.in_service), 1);
      check("s1_ack_pending",    int'(pending), 0);
      pulse_ret();
      check("s1_ret_in_service", int'(hz.in_service), 0);
      tick(2);
      check("s1_idle_interrupt", int'(hz.interrupt), 0);

      // priority and frozen request
      c = cyc;
      irq_lines = 8'h24;
      expect_req(2, 'h18, c + 2);
      tick();
      irq_lines = '0;
      wait_drained("s2a");
      irq_lines[0] = 1'b1;
      tick();
      irq_lines[0] = 1'b0;
      tick();
      check("s2_frozen_vector", int'(hz.interrupt_vector_address), 'h18);
      check("s2_frozen_active", int'(hz.active_irq), 2);
      check("s2_pending",       int'(pending), 'h25);
      pulse_ack();
      c = cyc;
      expect_req(0, 'h10, c + 2);
      pulse_ret();
      wait_drained("s2b");
      pulse_ack();
      c = cyc;
      expect_req(5, 'h24, c + 2);
      pulse_ret();
      wait_drained("s2c");
      pulse_ack();
      pulse_ret();
      tick(2);
      check("s2_done_pending", int'(pending), 0);

      // masking
      irq_enable_we = 1'b1; irq_enable_wdata = 8'h00;
      tick();
      irq_enable_we = 1'b0;
      irq_lines[1] = 1'b1;
      tick();
      irq_lines[1] = 1'b0;
      tick(3);
      check("s3_masked_interrupt", int'(hz.interrupt), 0);
      check("s3_masked_pending",   int'(pending), 'h02);
      c = cyc;
      irq_enable_we = 1'b1; irq_enable_wdata = 8'h02;
      expect_req(1, 'h14, c + 2);
      tick();
      irq_enable_we = 1'b0;
      wait_drained("s3");
      pulse_ack();
      pulse_ret();
      irq_enable_we = 1'b1; irq_enable_wdata = 8'hFF;
      tick();
      irq_enable_we = 1'b0;

      // gating and ignored strobes
      global_enable = 1'b0;
      irq_lines[4] = 1'b1;
      tick();
      irq_lines[4] = 1'b0;
      tick(3);
      check("s4_gated_interrupt", int'(hz.interrupt), 0);
      pulse_ack();
      check("s4_idle_ack_in_service", int'(hz.in_service), 0);
      check("s4_idle_ack_pending",    int'(pending), 'h10);
      c = cyc;
      global_enable = 1'b1;
      expect_req(4, 'h20, c + 1);
      tick();
      wait_drained("s4a");
      pulse_ret();
      check("s4_req_ret_interrupt",  int'(hz.interrupt), 1);
      check("s4_req_ret_in_service", int'(hz.in_service), 0);
      global_enable = 1'b0;
      tick();
      check("s4_ge_drop_interrupt", int'(hz.interrupt), 1);
      global_enable = 1'b1;
      pulse_ack();
      irq_lines[6] = 1'b1;
      tick();
      irq_lines[6] = 1'b0;
      tick(3);
      check("s4_svc_interrupt",  int'(hz.interrupt), 0);
      check("s4_svc_in_service", int'(hz.in_service), 1);
      check("s4_svc_pending",    int'(pending), 'h40);
      c = cyc;
      expect_req(6, 'h28, c + 2);
      pulse_ret();
      wait_drained("s4b");
      pulse_ack();
      pulse_ret();

      // edge on the active line coinciding with ack
      c = cyc;
      irq_lines[7] = 1'b1;
      expect_req(7, 'h2C, c + 2);
      tick();
      irq_lines[7] = 1'b0;
      wait_drained("s5a");
      irq_lines[7] = 1'b1;
      hz.int_ack   = 1'b1;
      tick();
      irq_lines[7] = 1'b0;
      hz.int_ack   = 1'b0;
      check("s5_collision_pending",    int'(pending), 'h80);
      check("s5_collision_in_service", int'(hz.in_service), 1);
      c = cyc;
      expect_req(7, 'h2C, c + 2);
      pulse_ret();
      wait_drained("s5b");
      pulse_ack();
      pulse_ret();

      // reset while in service
      c = cyc;
      irq_lines[3] = 1'b1;
      expect_req(3, 'h1C, c + 2);
      tick();
      irq_lines[3] = 1'b0;
      wait_drained("s6");
      pulse_ack();
      irq_lines[5] = 1'b1;
      tick();
      irq_lines[5] = 1'b0;
      reset = 1'b1;
      tick();
      reset = 1'b0;
      check("s6_rst_interrupt",  int'(hz.interrupt), 0);
      check("s6_rst_vector",     int'(hz.interrupt_vector_address), 0);
      check("s6_rst_in_service", int'(hz.in_service), 0);
      check("s6_rst_active",     int'(hz.active_irq), 0);
      check("s6_rst_pending",    int'(pending), 0);
      check("s6_rst_enable",     int'(irq_enable), 0);
      tick(3);
      check("s6_post_rst_interrupt", int'(hz.interrupt), 0);

      // vector wrap on the second instance
      w_we = 1'b1; w_wdata = 8'hFF;
      tick();
      w_we = 1'b0;
      w_lines[1] = 1'b1;
      tick();
      w_lines[1] = 1'b0;
      tick(2);
      check("wrap_interrupt", int'(w_hz.interrupt), 1);
      check("wrap_active",    int'(w_hz.active_irq), 1);
      check("wrap_vector",    int'(w_hz.interrupt_vector_address), 'h0000);

      tick(2);
      check("queue_empty", exp_q.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
